// File: rtl/matrix_uart_printer_if.sv
// Control and storage-read bundle for matrix_uart_printer.
// The slave modport is the printer side; the master modport is the controller/storage side.
interface matrix_uart_printer_if;
    logic        i_start;
    logic [8:0]  i_base_addr;
    logic [31:0] i_m;
    logic [31:0] i_n;
    logic [8:0]  o_rd_addr;
    logic [31:0] i_rd_data;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    modport slave (
        input  i_start, i_base_addr, i_m, i_n, i_rd_data,
        output o_rd_addr, o_busy, o_done, o_error
    );

    modport master (
        output i_start, i_base_addr, i_m, i_n, i_rd_data,
        input  o_rd_addr, o_busy, o_done, o_error
    );
endinterface

// File: rtl/matrix_uart_printer.sv
// Reads an m x n matrix of signed 32-bit words row-major and prints it as ASCII decimal over UART 8N1.
// Define MATRIX_PRINT_HEADER_EN to prefix the output with an "m*n\r\n" header line.
module matrix_uart_printer #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned MAX_DIM      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_uart_printer_if.slave  bus,
    output logic                  uart_tx_pin
);
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned DimW = $clog2(MAX_DIM + 1);

    typedef enum logic [3:0] {
        StIdle, StHdr, StRdReq, StRdWait, StSign, StDigit, StSep, StEolCr, StEolLf, StFinish
    } state_t;

    state_t            r_state;
    logic [8:0]        r_addr;
    logic [8:0]        r_rd_addr;
    logic [DimW-1:0]   r_m, r_n, r_row, r_col;
    logic              r_wait, r_neg, r_started;
    logic [31:0]       r_mag;
    logic [3:0]        r_pow, r_cnt;
    logic              r_busy, r_done, r_error;
`ifdef MATRIX_PRINT_HEADER_EN
    logic [2:0]        r_hdr_idx;
`endif

    logic              r_tx, r_tx_active;
    logic [3:0]        r_tx_bit;
    logic [CntW-1:0]   r_tx_clk;
    logic [7:0]        r_tx_data;

    logic              w_dim_bad, w_stop_end, w_tx_ready, w_want, w_tx_load, w_digit_done;
    logic [7:0]        w_byte;
    logic [31:0]       w_pow, w_rd_mag;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    return 32'd1;
            4'd1:    return 32'd10;
            4'd2:    return 32'd100;
            4'd3:    return 32'd1000;
            4'd4:    return 32'd10000;
            4'd5:    return 32'd100000;
            4'd6:    return 32'd1000000;
            4'd7:    return 32'd10000000;
            4'd8:    return 32'd100000000;
            default: return 32'd1000000000;
        endcase
    endfunction

    assign w_dim_bad = (bus.i_m == 32'd0) || (bus.i_n == 32'd0) ||
                       (bus.i_m > MAX_DIM) || (bus.i_n > MAX_DIM);
    // Unsigned negation so 0x80000000 yields 2147483648.
    assign w_rd_mag  = bus.i_rd_data[31] ? (~bus.i_rd_data + 32'd1) : bus.i_rd_data;
    assign w_pow        = pow10(r_pow);
    assign w_digit_done = (r_mag < w_pow);
    assign w_stop_end   = r_tx_active && (r_tx_bit == 4'd9) &&
                          (r_tx_clk == CntW'(CLKS_PER_BIT - 1));
    // Loading on the last stop-bit cycle keeps frames back-to-back.
    assign w_tx_ready   = !r_tx_active || w_stop_end;
    assign w_tx_load    = w_want && w_tx_ready;

    always_comb begin
        w_want = 1'b0;
        w_byte = 8'h00;
        case (r_state)
`ifdef MATRIX_PRINT_HEADER_EN
            StHdr: begin
                w_want = 1'b1;
                case (r_hdr_idx)
                    3'd0:    w_byte = 8'h30 + 8'(r_m);
                    3'd1:    w_byte = 8'h2A;
                    3'd2:    w_byte = 8'h30 + 8'(r_n);
                    3'd3:    w_byte = 8'h0D;
                    default: w_byte = 8'h0A;
                endcase
            end
`endif
            StSign:  begin w_want = r_neg;  w_byte = 8'h2D; end
            StDigit: begin
                w_want = w_digit_done && ((r_cnt != 4'd0) || r_started || (r_pow == 4'd0));
                w_byte = 8'h30 + {4'd0, r_cnt};
            end
            StSep:   begin w_want = 1'b1; w_byte = 8'h20; end
            StEolCr: begin w_want = 1'b1; w_byte = 8'h0D; end
            StEolLf: begin w_want = 1'b1; w_byte = 8'h0A; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_addr <= '0; r_rd_addr <= '0;
            r_m <= '0; r_n <= '0; r_row <= '0; r_col <= '0;
            r_wait <= 1'b0; r_neg <= 1'b0; r_started <= 1'b0;
            r_mag <= '0; r_pow <= '0; r_cnt <= '0;
            r_busy <= 1'b0; r_done <= 1'b0; r_error <= 1'b0;
`ifdef MATRIX_PRINT_HEADER_EN
            r_hdr_idx <= '0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                StIdle: if (bus.i_start && !r_done) begin
                    if (w_dim_bad) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                    end else begin
                        r_busy <= 1'b1;
                        r_addr <= bus.i_base_addr;
                        r_m    <= DimW'(bus.i_m);
                        r_n    <= DimW'(bus.i_n);
                        r_row  <= '0;
                        r_col  <= '0;
`ifdef MATRIX_PRINT_HEADER_EN
                        r_hdr_idx <= '0;
                        r_state   <= StHdr;
`else
                        r_state <= StRdReq;
`endif
                    end
                end
`ifdef MATRIX_PRINT_HEADER_EN
                StHdr: if (w_tx_load) begin
                    r_hdr_idx <= r_hdr_idx + 3'd1;
                    if (r_hdr_idx == 3'd4) r_state <= StRdReq;
                end
`endif
                StRdReq: begin
                    r_rd_addr <= r_addr;
                    r_wait    <= 1'b0;
                    r_state   <= StRdWait;
                end
                StRdWait: if (!r_wait) begin
                    r_wait <= 1'b1;
                end else begin
                    r_neg     <= bus.i_rd_data[31];
                    r_mag     <= w_rd_mag;
                    r_pow     <= 4'd9;
                    r_cnt     <= 4'd0;
                    r_started <= 1'b0;
                    r_state   <= StSign;
                end
                StSign: if (!r_neg || w_tx_load) r_state <= StDigit;
                StDigit: if (!w_digit_done) begin
                    r_mag <= r_mag - w_pow;
                    r_cnt <= r_cnt + 4'd1;
                end else if (!w_want || w_tx_load) begin
                    if (r_pow == 4'd0) begin
                        r_state <= (r_col == r_n - 1'b1) ? StEolCr : StSep;
                    end else begin
                        r_pow <= r_pow - 4'd1;
                        r_cnt <= 4'd0;
                        if (r_cnt != 4'd0) r_started <= 1'b1;
                    end
                end
                StSep: if (w_tx_load) begin
                    r_col   <= r_col + 1'b1;
                    r_addr  <= r_addr + 9'd1;
                    r_state <= StRdReq;
                end
                StEolCr: if (w_tx_load) r_state <= StEolLf;
                StEolLf: if (w_tx_load) begin
                    if (r_row == r_m - 1'b1) begin
                        r_state <= StFinish;
                    end else begin
                        r_row   <= r_row + 1'b1;
                        r_col   <= '0;
                        r_addr  <= r_addr + 9'd1;
                        r_state <= StRdReq;
                    end
                end
                StFinish: if (!r_tx_active || w_stop_end) begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx        <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_bit    <= '0;
            r_tx_clk    <= '0;
            r_tx_data   <= '0;
        end else if (w_tx_load) begin
            r_tx        <= 1'b0;
            r_tx_active <= 1'b1;
            r_tx_bit    <= '0;
            r_tx_clk    <= '0;
            r_tx_data   <= w_byte;
        end else if (r_tx_active) begin
            if (r_tx_clk == CntW'(CLKS_PER_BIT - 1)) begin
                r_tx_clk <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_active <= 1'b0;
                    r_tx        <= 1'b1;
                end else begin
                    r_tx_bit <= r_tx_bit + 4'd1;
                    r_tx     <= (r_tx_bit == 4'd8) ? 1'b1 : r_tx_data[r_tx_bit[2:0]];
                end
            end else begin
                r_tx_clk <= r_tx_clk + 1'b1;
            end
        end
    end

    assign bus.o_rd_addr = r_rd_addr;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_error   = r_error;
    assign uart_tx_pin   = r_tx;
endmodule
